// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time. It samples
// the (synchronized) row lines once per column and then classifies each full
// 16-key scan as no key, exactly one key, or several keys. It debounces press
// and release over whole scans before reporting a key.
//
// Parameters:
//   SCAN_TICKS     - clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS - consecutive matching scans needed to accept a press
//                    or a release (>= 1)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   key_r     in   [3:0] row sense lines, active-low, asynchronous to clk
//   key_c     out  [3:0] column drive, active-low one-hot, registered
//   key_code  out  [3:0] last accepted key, col*4 + row
//   key_valid out  one-cycle pulse on each newly accepted press
//   key_held  out  high from accepted press until accepted release
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_TICKS     = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_r,
    output logic [3:0] key_c,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] tick;
    logic [1:0]    col;
    logic [11:0]   scan_buf;
    logic [15:0]   full_scan;
    logic [1:0]    hits;
    logic [3:0]    hit_key;
    scan_kind_t    scan_class;

    logic          scan_done;
    scan_kind_t    scan_kind;
    logic [3:0]    scan_key;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic [3:0]    candidate;
    logic          is_single;
    logic          held_match;

    // The idle rows read high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= key_r;
            row_sync <= row_meta;
        end
    end

    // Columns 0..2 come from the buffer. Column 3 is taken live from the
    // synchronizer, so the scan is classified on the column-3 sample cycle.
    assign full_scan = {~row_sync, scan_buf};

    always_comb begin
        hits    = 2'd0;
        hit_key = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_scan[i]) begin
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
                hit_key = 4'(i);
            end
        end
        case (hits)
            2'd0:    scan_class = SCAN_NONE;
            2'd1:    scan_class = SCAN_SINGLE;
            default: scan_class = SCAN_MULTI;
        endcase
    end

    // The column advance and the row sample happen on the same last tick.
    // By that tick the current column has been driven long enough for the
    // lines and the synchronizer to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick      <= '0;
            col       <= 2'd0;
            key_c     <= 4'b1110;
            scan_buf  <= '0;
            scan_done <= 1'b0;
            scan_kind <= SCAN_NONE;
            scan_key  <= 4'd0;
        end else begin
            scan_done <= 1'b0;
            if (tick == TICK_LAST) begin
                tick  <= '0;
                col   <= col + 2'd1;
                key_c <= ~(4'b0001 << (col + 2'd1));
                case (col)
                    2'd0: scan_buf[3:0]  <= ~row_sync;
                    2'd1: scan_buf[7:4]  <= ~row_sync;
                    2'd2: scan_buf[11:8] <= ~row_sync;
                    default: begin
                        scan_done <= 1'b1;
                        scan_kind <= scan_class;
                        scan_key  <= hit_key;
                    end
                endcase
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c >= COUNT_MAX) begin
            return COUNT_MAX;
        end
        return c + CW'(1);
    endfunction

    assign next_count = sat_inc(count);
    assign is_single  = (scan_kind == SCAN_SINGLE);
    assign held_match = is_single && (scan_key == key_code);

    // The debounce FSM advances once per completed scan. The release path
    // compares against key_code, which always holds the currently held key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            candidate <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            candidate <= scan_key;
                            count     <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= HELD;
                                key_code  <= scan_key;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                            end else begin
                                state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (is_single && (scan_key == candidate)) begin
                            count <= next_count;
                            if (next_count == COUNT_MAX) begin
                                state     <= HELD;
                                key_code  <= candidate;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                            end
                        end else if (is_single) begin
                            candidate <= scan_key;
                            count     <= CW'(1);
                        end else begin
                            state <= IDLE;
                            count <= '0;
                        end
                    end
                    HELD: begin
                        if (!held_match) begin
                            count <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state <= RELEASE_DB;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (held_match) begin
                            state <= HELD;
                            count <= '0;
                        end else begin
                            count <= next_count;
                            if (next_count == COUNT_MAX) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_TICKS=4 and DEBOUNCE_SCANS=3, so one
// scan lasts 16 cycles. A keypad model drives the rows from the columns and
// a 16-bit "pressed" map. Each scan holds one pattern. After each scan ends,
// the outputs are compared with a hand-written table and with a reference
// model that works on the history of scan results.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int TICKS = 4;
    localparam int DB    = 3;

    logic       clk;
    logic       rst;
    logic [3:0] key_r;
    logic [3:0] key_c;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;

    int vectors;
    int miscompares;
    int edgeCount;

    // The reference model keeps every scan result since reset: -1 none,
    // -2 multi, 0..15 single key. modeStart marks the first scan that counts
    // toward the current press or release.
    int   scans[$];
    int   modeStart;
    logic modelHeld;
    int   modelCode;
    logic modelPulse;

    typedef struct {
        logic [15:0] pat;
        logic        expValid;
        logic        expHeld;
        logic [3:0]  expCode;
    } vec_t;

    vec_t tbl[$];

    keypad_scanner #(
        .SCAN_TICKS(TICKS),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_r(key_r),
        .key_c(key_c),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        key_r = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!key_c[c]) begin
                key_r = key_r & ~pressed[c*4 +: 4];
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic int classify(input logic [15:0] pat);
        int idx;
        idx = 0;
        if ($countones(pat) == 0) return -1;
        if ($countones(pat) > 1) return -2;
        for (int i = 0; i < 16; i++) begin
            if (pat[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic modelReset();
        scans.delete();
        modeStart  = 0;
        modelHeld  = 1'b0;
        modelCode  = 0;
        modelPulse = 1'b0;
    endtask

    task automatic modelUpdate(input int result);
        int run;
        scans.push_back(result);
        modelPulse = 1'b0;
        run = 0;
        if (!modelHeld) begin
            if (result >= 0) begin
                for (int i = scans.size() - 1; i >= modeStart && scans[i] == result; i--) run++;
            end
            if (run == DB) begin
                modelHeld  = 1'b1;
                modelCode  = result;
                modelPulse = 1'b1;
                modeStart  = scans.size();
            end
        end else begin
            for (int i = scans.size() - 1; i >= modeStart && scans[i] != modelCode; i--) run++;
            if (run == DB) begin
                modelHeld = 1'b0;
                modeStart = scans.size();
            end
        end
    endtask

    task automatic stepEdge();
        logic [3:0] one4;
        logic [3:0] expC;
        @(posedge clk);
        #1;
        edgeCount++;
        one4 = 4'b0001;
        expC = ~(one4 << ((edgeCount / TICKS) % 4));
        checkOutput("key_c", key_c, expC);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        checkOutput("reset_key_c", key_c, 4'b1110);
        checkOutput("reset_key_code", key_code, 4'h0);
        checkOutput("reset_key_valid", {3'b000, key_valid}, 4'h0);
        checkOutput("reset_key_held", {3'b000, key_held}, 4'h0);
        pressed = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        edgeCount = 0;
        stepEdge();
    endtask

    // Starts one cycle after a scan begins and holds the pattern for the
    // whole scan. It ends just after the debounce update for that scan.
    // A nonzero abortAt returns early, before the update.
    task automatic applyStimulus(input logic [15:0] pat, input int abortAt);
        pressed = pat;
        for (int i = 1; i <= 16; i++) begin
            stepEdge();
            if (abortAt != 0 && i == abortAt) return;
            if (i < 16) checkOutput("key_valid_quiet", {3'b000, key_valid}, 4'h0);
        end
        modelUpdate(classify(pat));
        checkOutput("model_key_valid", {3'b000, key_valid}, {3'b000, modelPulse});
        checkOutput("model_key_held", {3'b000, key_held}, {3'b000, modelHeld});
        checkOutput("model_key_code", key_code, modelCode[3:0]);
    endtask

    task automatic addVec(input logic [15:0] pat, input logic v, input logic h, input logic [3:0] c);
        vec_t e;
        e.pat      = pat;
        e.expValid = v;
        e.expHeld  = h;
        e.expCode  = c;
        tbl.push_back(e);
    endtask

    initial begin
        logic [15:0] one16;
        logic [15:0] pat;
        int kind;
        int a;
        int b;
        int len;
        int favKey;

        vectors     = 0;
        miscompares = 0;
        edgeCount   = 0;
        rst         = 1'b1;
        pressed     = 16'h0000;
        one16       = 16'h0001;
        modelReset();

        // idle scanning with no keys
        for (int i = 0; i < 10; i++) addVec(16'h0000, 1'b0, 1'b0, 4'h0);
        // key 9 (col 2, row 1) accepted on the third scan
        addVec(16'h0200, 1'b0, 1'b0, 4'h0);
        addVec(16'h0200, 1'b0, 1'b0, 4'h0);
        addVec(16'h0200, 1'b1, 1'b1, 4'h9);
        addVec(16'h0200, 1'b0, 1'b1, 4'h9);
        // one-scan dropout, then release after three empty scans
        addVec(16'h0000, 1'b0, 1'b1, 4'h9);
        addVec(16'h0200, 1'b0, 1'b1, 4'h9);
        addVec(16'h0000, 1'b0, 1'b1, 4'h9);
        addVec(16'h0000, 1'b0, 1'b1, 4'h9);
        addVec(16'h0000, 1'b0, 1'b0, 4'h9);
        // keys 0 and 5 together never count as a press
        for (int i = 0; i < 6; i++) addVec(16'h0021, 1'b0, 1'b0, 4'h9);
        // key 3 then key 7: the candidate restarts
        addVec(16'h0008, 1'b0, 1'b0, 4'h9);
        addVec(16'h0008, 1'b0, 1'b0, 4'h9);
        addVec(16'h0080, 1'b0, 1'b0, 4'h9);
        addVec(16'h0080, 1'b0, 1'b0, 4'h9);
        addVec(16'h0080, 1'b1, 1'b1, 4'h7);
        addVec(16'h0000, 1'b0, 1'b1, 4'h7);
        addVec(16'h0000, 1'b0, 1'b1, 4'h7);
        addVec(16'h0000, 1'b0, 1'b0, 4'h7);
        // a second key while one is held gives no pulse until a new debounce
        addVec(16'h0080, 1'b0, 1'b0, 4'h7);
        addVec(16'h0080, 1'b0, 1'b0, 4'h7);
        addVec(16'h0080, 1'b1, 1'b1, 4'h7);
        addVec(16'h0084, 1'b0, 1'b1, 4'h7);
        addVec(16'h0084, 1'b0, 1'b1, 4'h7);
        addVec(16'h0004, 1'b0, 1'b0, 4'h7);
        addVec(16'h0004, 1'b0, 1'b0, 4'h7);
        addVec(16'h0004, 1'b0, 1'b0, 4'h7);
        addVec(16'h0004, 1'b1, 1'b1, 4'h2);
        addVec(16'h0000, 1'b0, 1'b1, 4'h2);
        addVec(16'h0000, 1'b0, 1'b1, 4'h2);
        addVec(16'h0000, 1'b0, 1'b0, 4'h2);

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].pat, 0);
            checkOutput($sformatf("tbl%0d_valid", i), {3'b000, key_valid}, {3'b000, tbl[i].expValid});
            checkOutput($sformatf("tbl%0d_held", i), {3'b000, key_held}, {3'b000, tbl[i].expHeld});
            checkOutput($sformatf("tbl%0d_code", i), key_code, tbl[i].expCode);
        end

        // Reset in the middle of a debounce discards the partial count.
        doReset();
        applyStimulus(16'h0200, 0);
        applyStimulus(16'h0200, 0);
        applyStimulus(16'h0200, 7);
        doReset();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(16'h0200, 0);
            checkOutput($sformatf("rst_mid_valid%0d", i), {3'b000, key_valid}, (i == 3) ? 4'h1 : 4'h0);
            checkOutput($sformatf("rst_mid_held%0d", i), {3'b000, key_held}, (i == 3) ? 4'h1 : 4'h0);
        end

        // Randomized runs. Single presses favour one key so that long runs,
        // restarts and dropouts all occur.
        doReset();
        favKey = $urandom_range(0, 15);
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 5);
            if (kind < 4) begin
                pat = one16 << favKey;
            end else if (kind < 6) begin
                pat = one16 << $urandom_range(0, 15);
            end else if (kind < 8) begin
                pat = 16'h0000;
            end else begin
                a   = $urandom_range(0, 15);
                b   = (a + $urandom_range(1, 15)) % 16;
                pat = (one16 << a) | (one16 << b);
            end
            for (int s = 0; s < len; s++) applyStimulus(pat, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 1024, SHALL set the clock cycles each column is driven (minimum 4).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, SHALL set the consecutive full scans needed to accept a press or a release (minimum 1).
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 KEY_R  input  4  SHALL be the keypad row sense lines: active-low, externally pulled up, asynchronous to CLK.
REQ-006 KEY_C  output  4  SHALL be the column drive: active-low one-hot, registered.
REQ-007 KEY_CODE  output  4  SHALL be the accepted key code, col*4 + row, held stable until the next accepted press.
REQ-008 KEY_VALID  output  1  SHALL be a single-cycle pulse marking a newly accepted press.
REQ-009 KEY_HELD  output  1  SHALL be a level, high from an accepted press until its accepted release.

Function
REQ-010 KEY_R SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A tick counter SHALL run 0..SCAN_TICKS-1; at wrap the column index SHALL advance 0->1->2->3->0 and KEY_C SHALL drive ~(1<<col).
REQ-012 Rows SHALL be sampled only on the cycle where tick == SCAN_TICKS-1, so the synchronizer and lines have settled for the current column.
REQ-013 A full scan SHALL end at the column-3 sample and classify its 16 samples as NONE, SINGLE(k) or MULTI (two or more keys).
REQ-014 The debounce FSM SHALL update once per full scan, on the cycle after the column-3 sample.
REQ-015 FSM states SHALL be IDLE, PRESS_DB, HELD and RELEASE_DB, with a candidate code and a debounce count.
REQ-016 IDLE: on SINGLE(k), set candidate=k, count=1 and go to PRESS_DB; on NONE or MULTI, stay.
REQ-017 PRESS_DB: SINGLE(candidate) SHALL increment count; SINGLE(j != candidate) SHALL restart with candidate=j, count=1; NONE or MULTI SHALL return to IDLE.
REQ-018 When count reaches DEBOUNCE_SCANS in PRESS_DB, the FSM SHALL go to HELD; on the same update KEY_CODE=candidate, KEY_HELD=1, and KEY_VALID pulses for exactly one cycle.
REQ-019 If DEBOUNCE_SCANS == 1, IDLE SHALL go directly to HELD on SINGLE(k) with the REQ-018 outputs.
REQ-020 HELD: SINGLE(KEY_CODE) SHALL stay in HELD; any other result (NONE, MULTI, SINGLE of another key) SHALL go to RELEASE_DB with count=1.
REQ-021 RELEASE_DB: SINGLE(KEY_CODE) SHALL return to HELD with no KEY_VALID pulse.
REQ-022 RELEASE_DB: any other result SHALL increment count; when count reaches DEBOUNCE_SCANS the FSM SHALL go to IDLE, KEY_HELD=0, and KEY_CODE SHALL remain unchanged.
REQ-023 A second key pressed while one is held SHALL NOT generate KEY_VALID until the held key is released and a new press is debounced.
REQ-024 The debounce count SHALL saturate at DEBOUNCE_SCANS and never wrap.
REQ-025 Scanning SHALL be free-running in every FSM state and never stall.

Reset
REQ-026 RST high SHALL immediately force: tick=0, col=0, KEY_C=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0, FSM=IDLE, count=0, candidate=0, synchronizer flops=4'b1111.
REQ-027 Reset asserted mid-scan or mid-debounce SHALL discard all partial results; the first scan after release SHALL start at column 0, tick 0.
REQ-028 Reset deassertion SHALL take effect on a CLK edge, with no output glitch on KEY_C.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=3; one scan = 16 cycles)
REQ-029 Reset, no keys, 10 scans -> KEY_C cycles 1110,1101,1011,0111 every 4 cycles; KEY_VALID never high; KEY_HELD=0.
REQ-030 Key col 2, row 1 held steady -> one KEY_VALID pulse at the third scan-end update; KEY_CODE=9; KEY_HELD=1; no further pulses while held.
REQ-031 Key 9 held, then 1-scan dropout, then held again -> stays/returns HELD, no new pulse; after 3 clean NONE scans -> KEY_HELD=0, KEY_CODE still 9.
REQ-032 Keys 0 and 5 pressed together for 6 scans -> classified MULTI; no KEY_VALID; FSM stays IDLE.
REQ-033 Press key 3 for 2 scans, then key 7 for 3 scans -> candidate restarts; one pulse, KEY_CODE=7.
REQ-034 Key 9 in PRESS_DB with count=2, RST pulsed mid-scan -> all outputs at reset values; a full 3 scans are needed before KEY_VALID.
